mux_4_to_1_rr_arbiter: RTL and testbench

//   Shares one mux_4_to_1 datapath between four requesters using round-robin arbitration.

---
 rtl/mux_arb_pkg.sv | 31 +++
 rtl/mux_4_to_1.sv | 23 ++
 rtl/mux_4_to_1_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_mux_4_to_1_rr_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state type and round-robin pick function for mux_4_to_1_rr_arbiter.
package mux_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned HOLD_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First set request scanning last+1, last+2, ... modulo NUM_REQ; returns last if none set.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                  input logic [SEL_W-1:0]   last);
        logic [SEL_W-1:0] pick;
        logic [SEL_W-1:0] idx;
        logic             found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            idx = SEL_W'(int'(last) + i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_4_to_1.sv
// Plain 4:1 multiplexer; z selects a/b/c/d by sel.
module mux_4_to_1 #(
    parameter int unsigned INPUT_BIT_LENGTH = 1
) (
    input  logic [INPUT_BIT_LENGTH-1:0] a,
    input  logic [INPUT_BIT_LENGTH-1:0] b,
    input  logic [INPUT_BIT_LENGTH-1:0] c,
    input  logic [INPUT_BIT_LENGTH-1:0] d,
    input  logic [1:0]                  sel,
    output logic [INPUT_BIT_LENGTH-1:0] z
);

    always_comb begin
        z = a;
        case (sel)
            2'd0:    z = a;
            2'd1:    z = b;
            2'd2:    z = c;
            default: z = d;
        endcase
    end

endmodule

// File: rtl/mux_4_to_1_rr_arbiter.sv
// Round-robin arbiter sharing one mux_4_to_1 among four requesters.
// Optional per-requester grant counters are enabled with MUX_ARB_GRANT_CNT_EN.
module mux_4_to_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned INPUT_BIT_LENGTH = 1,
    parameter int unsigned MAX_HOLD         = 8
`ifdef MUX_ARB_GRANT_CNT_EN
    ,parameter int unsigned CNT_WIDTH       = 16
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [INPUT_BIT_LENGTH-1:0] a,
    input  logic [INPUT_BIT_LENGTH-1:0] b,
    input  logic [INPUT_BIT_LENGTH-1:0] c,
    input  logic [INPUT_BIT_LENGTH-1:0] d,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [SEL_W-1:0]            sel,
    output logic [INPUT_BIT_LENGTH-1:0] z,
    output logic                        z_valid
`ifdef MUX_ARB_GRANT_CNT_EN
    ,output logic [NUM_REQ*CNT_WIDTH-1:0] grant_cnt
`endif
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                z_valid_q, z_valid_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0]    pick;
    logic                others_pending;

    assign pick           = rr_pick(req, last_q);
    assign others_pending = |(req & ~gnt_q);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        z_valid_d  = z_valid_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                gnt_d     = '0;
                z_valid_d = 1'b0;
                if (|req) begin
                    gnt_d      = NUM_REQ'(1) << pick;
                    sel_d      = pick;
                    z_valid_d  = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // Owner drops its request, or is pre-empted after MAX_HOLD cycles under contention.
                if (!req[sel_q] || (hold_cnt_q == HOLD_LAST && others_pending)) begin
                    gnt_d     = '0;
                    z_valid_d = 1'b0;
                    last_d    = sel_q;
                    state_d   = IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            z_valid_q  <= 1'b0;
            last_q     <= SEL_W'(NUM_REQ - 1);
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            z_valid_q  <= z_valid_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign z_valid = z_valid_q;

    mux_4_to_1 #(
        .INPUT_BIT_LENGTH(INPUT_BIT_LENGTH)
    ) u_mux (
        .a  (a),
        .b  (b),
        .c  (c),
        .d  (d),
        .sel(sel_q),
        .z  (z)
    );

`ifdef MUX_ARB_GRANT_CNT_EN
    logic [NUM_REQ-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Count each new grant (IDLE->GRANT), saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && (|req) && (cnt_q[pick] != '1)) begin
            cnt_d[pick] = cnt_q[pick] + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_4_to_1_rr_arbiter.sv
// Directed self-checking bench for mux_4_to_1_rr_arbiter (grant counter checks under MUX_ARB_GRANT_CNT_EN).
module tb_mux_4_to_1_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       a, b, c, d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       z;
    logic       z_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef MUX_ARB_GRANT_CNT_EN
    logic [63:0] grant_cnt;
    logic [3:0]  gnt_s;
    logic [1:0]  sel_s;
    logic        z_s;
    logic        z_valid_s;
    logic [7:0]  grant_cnt_s;

    mux_4_to_1_rr_arbiter #(
        .INPUT_BIT_LENGTH(1),
        .MAX_HOLD        (8),
        .CNT_WIDTH       (2)
    ) u_dut_sat (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .gnt      (gnt_s),
        .sel      (sel_s),
        .z        (z_s),
        .z_valid  (z_valid_s),
        .grant_cnt(grant_cnt_s)
    );
`endif

    mux_4_to_1_rr_arbiter #(
        .INPUT_BIT_LENGTH(1),
        .MAX_HOLD        (8)
`ifdef MUX_ARB_GRANT_CNT_EN
        ,.CNT_WIDTH      (16)
`endif
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .gnt    (gnt),
        .sel    (sel),
        .z      (z),
        .z_valid(z_valid)
`ifdef MUX_ARB_GRANT_CNT_EN
        ,.grant_cnt(grant_cnt)
`endif
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] req;
        logic       a, b, c, d;
        int         n;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       zv;
        logic       z;
    } vec_t;

    function automatic vec_t v(string name, logic r, logic [3:0] rq,
                               logic ia, logic ib, logic ic, logic id, int n,
                               logic [3:0] eg, logic [1:0] es, logic ezv, logic ez);
        vec_t t;
        t.name = name; t.rst = r; t.req = rq;
        t.a = ia; t.b = ib; t.c = ic; t.d = id; t.n = n;
        t.gnt = eg; t.sel = es; t.zv = ezv; t.z = ez;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock edge, then compare outputs away from the edge.
    task automatic step_chk(string name, logic [3:0] eg, logic [1:0] es, logic ezv, logic ez);
        @(posedge clk);
        #1;
        chk({name, ".gnt"}, 32'(gnt), 32'(eg));
        chk({name, ".sel"}, 32'(sel), 32'(es));
        chk({name, ".z_valid"}, 32'(z_valid), 32'(ezv));
        chk({name, ".z"}, 32'(z), 32'(ez));
        chk({name, ".onehot0"}, 32'($onehot0(gnt)), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        rst = 1'b1; req = 4'h0; a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b0;

        // Reset with all requests, first grant, uncontended hold, short pulse, reset mid-grant.
        vecs.push_back(v("rst_hold",   1'b1, 4'b1111, 1,0,0,1, 2,  4'b0000, 2'd0, 1'b0, 1'b1));
        vecs.push_back(v("first_gnt",  1'b0, 4'b1111, 1,0,0,1, 1,  4'b0001, 2'd0, 1'b1, 1'b1));
        vecs.push_back(v("drop0",      1'b0, 4'b0000, 1,0,0,1, 1,  4'b0000, 2'd0, 1'b0, 1'b1));
        vecs.push_back(v("only2",      1'b0, 4'b0100, 0,0,1,0, 20, 4'b0100, 2'd2, 1'b1, 1'b1));
        vecs.push_back(v("drop2",      1'b0, 4'b0000, 0,0,1,0, 1,  4'b0000, 2'd2, 1'b0, 1'b1));
        vecs.push_back(v("pulse1",     1'b0, 4'b0010, 0,1,0,0, 3,  4'b0010, 2'd1, 1'b1, 1'b1));
        vecs.push_back(v("pulse1_off", 1'b0, 4'b0000, 0,1,0,0, 2,  4'b0000, 2'd1, 1'b0, 1'b1));
        vecs.push_back(v("rst5",       1'b1, 4'b0000, 0,0,0,1, 1,  4'b0000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(v("own3",       1'b0, 4'b1000, 0,0,0,1, 1,  4'b1000, 2'd3, 1'b1, 1'b1));
        vecs.push_back(v("hold3",      1'b0, 4'b1111, 0,0,0,1, 4,  4'b1000, 2'd3, 1'b1, 1'b1));
        vecs.push_back(v("rst_mid",    1'b1, 4'b1111, 0,0,0,1, 1,  4'b0000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(v("post_rst",   1'b0, 4'b1111, 0,0,0,1, 1,  4'b0001, 2'd0, 1'b1, 1'b0));

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; req = vecs[i].req;
            a = vecs[i].a; b = vecs[i].b; c = vecs[i].c; d = vecs[i].d;
            for (int k = 0; k < vecs[i].n; k++) begin
                step_chk(vecs[i].name, vecs[i].gnt, vecs[i].sel, vecs[i].zv, vecs[i].z);
            end
        end

        // Contended 0/3 rotation: 8 cycles each, one idle cycle per handoff.
        rst = 1'b1; req = 4'b1001; a = 1'b1; b = 1'b0; c = 1'b0; d = 1'b1;
        step_chk("rot_rst", 4'b0000, 2'd0, 1'b0, 1'b1);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 8; k++) step_chk("rot_own0", 4'b0001, 2'd0, 1'b1, 1'b1);
            step_chk("rot_gap0", 4'b0000, 2'd0, 1'b0, 1'b1);
            for (int k = 0; k < 8; k++) step_chk("rot_own3", 4'b1000, 2'd3, 1'b1, 1'b1);
            step_chk("rot_gap3", 4'b0000, 2'd3, 1'b0, 1'b1);
        end
`ifdef MUX_ARB_GRANT_CNT_EN
        chk("cnt0", 32'(grant_cnt[15:0]),  32'd4);
        chk("cnt1", 32'(grant_cnt[31:16]), 32'd0);
        chk("cnt2", 32'(grant_cnt[47:32]), 32'd0);
        chk("cnt3", 32'(grant_cnt[63:48]), 32'd4);
        chk("sat_cnt0", 32'(grant_cnt_s[1:0]), 32'd3);
        chk("sat_cnt3", 32'(grant_cnt_s[7:6]), 32'd3);
`endif
        step_chk("rot_back0", 4'b0001, 2'd0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
